// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan path: BCD/segment types, converter states, nibble decode.
// Latency: none, pure definitions and a combinational decode function.
// Backpressure: not applicable.
package seg_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    // Active-low cathodes, bit 0 = segment a ... bit 6 = segment g.
    // Nibbles above 9 only appear while the time counter rolls over, so they show a dash.
    function automatic seg_t bcd_to_seg(input bcd_t bcd);
        seg_t seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter using double-dabble.
// Latency: start cycle, then 8 SHIFT cycles, then 1 DONE cycle; bcd is valid while done is high.
// Backpressure: none; a start while busy aborts the current conversion and restarts on the new value.
module bin2bcd8
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_t state, state_nxt;
    logic [19:0] sr;
    logic [19:0] sr_adj;
    logic [2:0]  bit_cnt;

    // Add 3 to every BCD nibble that is 5 or more, so the following shift carries correctly.
    always_comb begin
        sr_adj = sr;
        for (int n = 0; n < 3; n++) begin
            if (sr[8 + 4*n +: 4] >= 4'd5) begin
                sr_adj[8 + 4*n +: 4] = sr[8 + 4*n +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            SHIFT:   if (bit_cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (start) state_nxt = SHIFT;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                sr      <= {12'd0, bin};
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                sr      <= {sr_adj[18:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign bcd  = sr[19:8];

endmodule

// File: rtl/seg_display_scan.sv
// Scans a 28-bit time/points word onto an 8-digit common-anode 7-seg display; optional SEG_LEADING_ZERO_BLANK_EN.
// Latency: outputs registered one cycle after slot counter/index; input snapshotted once per frame.
// Backpressure: none; digit_in is only sampled at the start of each frame.
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 65000,
    parameter int BLANK_CYC = 16,
    parameter int DP_POS    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [27:0] digit_in,
    output logic [7:0]  an_out,
    output logic [6:0]  seg_out,
    output logic        dp_out
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] slot_cnt;
    logic [2:0]       idx;
    logic [19:0]      frame_time;
    logic [11:0]      pts_bcd;
    logic             slot_end;
    logic             snap;
    logic             conv_busy;
    logic             conv_done;
    logic [11:0]      conv_bcd;
    bcd_t             nib;
    logic             digit_blank;

    assign slot_end = (slot_cnt == CNT_W'(SCAN_DIV - 1));
    assign snap     = (slot_cnt == '0) && (idx == 3'd7);

    // idx wraps 0 -> 7 by natural 3-bit underflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_cnt   <= '0;
            idx        <= 3'd7;
            frame_time <= '0;
            pts_bcd    <= '0;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
            if (slot_end) idx <= idx - 3'd1;
            if (snap) frame_time <= digit_in[27:8];
            if (conv_done) pts_bcd <= conv_bcd;
        end
    end

    bin2bcd8 u_conv (
        .clk   (clk),
        .reset (reset),
        .start (snap),
        .bin   (digit_in[7:0]),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        nib         = 4'd0;
        digit_blank = 1'b0;
        case (idx)
            3'd7:    nib = frame_time[19:16];
            3'd6:    nib = frame_time[15:12];
            3'd5:    nib = frame_time[11:8];
            3'd4:    nib = frame_time[7:4];
            3'd3:    nib = frame_time[3:0];
            3'd2:    nib = pts_bcd[11:8];
            3'd1:    nib = pts_bcd[7:4];
            default: nib = pts_bcd[3:0];
        endcase
`ifdef SEG_LEADING_ZERO_BLANK_EN
        case (idx)
            3'd7:    digit_blank = (frame_time[19:16] == 4'd0);
            3'd6:    digit_blank = (frame_time[19:12] == 8'd0);
            3'd5:    digit_blank = (frame_time[19:8] == 12'd0);
            3'd2:    digit_blank = (pts_bcd[11:8] == 4'd0);
            3'd1:    digit_blank = (pts_bcd[11:4] == 8'd0);
            default: digit_blank = 1'b0;
        endcase
`endif
        // Never show a half-converted points value.
        if (idx <= 3'd2 && conv_busy) digit_blank = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset || slot_cnt < CNT_W'(BLANK_CYC)) begin
            an_out  <= 8'hFF;
            seg_out <= SEG_BLANK;
            dp_out  <= 1'b1;
        end else begin
            an_out  <= ~(8'd1 << idx);
            seg_out <= digit_blank ? SEG_BLANK : bcd_to_seg(nib);
            dp_out  <= !(idx == 3'(DP_POS));
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with SCAN_DIV=32, BLANK_CYC=2, DP_POS=4.
module tb_seg_display_scan;

    localparam int SD = 32;
    localparam int BC = 2;
    localparam int DP = 4;

    localparam logic [6:0] S0   = 7'h40;
    localparam logic [6:0] S1   = 7'h79;
    localparam logic [6:0] S2   = 7'h24;
    localparam logic [6:0] S3   = 7'h30;
    localparam logic [6:0] S4   = 7'h19;
    localparam logic [6:0] S5   = 7'h12;
    localparam logic [6:0] S6   = 7'h02;
    localparam logic [6:0] S7   = 7'h78;
    localparam logic [6:0] S8   = 7'h00;
    localparam logic [6:0] S9   = 7'h10;
    localparam logic [6:0] DASH = 7'h3F;
    localparam logic [6:0] BLK  = 7'h7F;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = BLK;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [27:0] digit_in = '0;
    logic [7:0]  an_out;
    logic [6:0]  seg_out;
    logic        dp_out;

    int tests = 0;
    int fails = 0;
    int cyc = -1;
    logic [6:0]  exp_seg [8];
    logic [11:0] exp_bcd = '0;

    seg_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .DP_POS(DP)) dut (
        .clk      (clk),
        .reset    (reset),
        .digit_in (digit_in),
        .an_out   (an_out),
        .seg_out  (seg_out),
        .dp_out   (dp_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
        end
    endtask

    task automatic step_chk();
        int c;
        int idx;
        logic [7:0] ea;
        logic       ed;
        @(posedge clk);
        #1;
        cyc++;
        c   = cyc % SD;
        idx = 7 - (cyc / SD) % 8;
        if (c < BC) begin
            chk("an_blank", an_out, 8'hFF);
            chk("seg_blank", seg_out, BLK);
            chk("dp_blank", dp_out, 1'b1);
        end else begin
            ea = ~(8'd1 << idx);
            ed = (idx == DP) ? 1'b0 : 1'b1;
            chk("an", an_out, ea);
            chk("seg", seg_out, exp_seg[idx]);
            chk("dp", dp_out, ed);
        end
        if (cyc % 256 == 7) chk("conv_not_done", dut.u_conv.done, 1'b0);
        if (cyc % 256 == 8) begin
            chk("conv_done", dut.u_conv.done, 1'b1);
            chk("conv_bcd", dut.u_conv.bcd, exp_bcd);
        end
        if (cyc % 256 == 9) begin
            chk("conv_pulse_end", dut.u_conv.done, 1'b0);
            chk("pts_bcd", dut.pts_bcd, exp_bcd);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step_chk();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_an", an_out, 8'hFF);
            chk("rst_seg", seg_out, BLK);
            chk("rst_dp", dp_out, 1'b1);
        end
        reset = 1'b1;
        cyc   = -1;
    endtask

    task automatic load(input logic [27:0] d,
                        input logic [6:0] e7, input logic [6:0] e6, input logic [6:0] e5,
                        input logic [6:0] e4, input logic [6:0] e3, input logic [6:0] e2,
                        input logic [6:0] e1, input logic [6:0] e0, input logic [11:0] b);
        digit_in   = d;
        exp_seg[7] = e7; exp_seg[6] = e6; exp_seg[5] = e5; exp_seg[4] = e4;
        exp_seg[3] = e3; exp_seg[2] = e2; exp_seg[1] = e1; exp_seg[0] = e0;
        exp_bcd    = b;
    endtask

    initial begin
        do_reset(5);

        load({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 8'd0}, S1, S2, S3, S4, S5, LZ, LZ, S0, 12'h000);
        run(256);

        load({4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 8'd255}, S9, S8, S7, S6, S5, S2, S5, S5, 12'h255);
        run(256);

        // Reset mid-scan, then the scan restarts at index 7 with a fresh snapshot.
        load({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 8'd0}, S1, S2, S3, S4, S5, LZ, LZ, S0, 12'h000);
        run(100);
        do_reset(5);
        run(256);

        // Mid-frame change at index 5 only shows up in the next frame.
        load({4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 8'd100}, S1, S0, S0, S0, S0, S1, S0, S0, 12'h100);
        run(74);
        digit_in = {4'd1, 4'd2, 4'd3, 4'd4, 4'hA, 8'd142};
        run(256 - 74);
        load({4'd1, 4'd2, 4'd3, 4'd4, 4'hA, 8'd142}, S1, S2, S3, S4, DASH, S1, S4, S2, 12'h142);
        run(256);

        // Reset while the converter is shifting 255: the result must be discarded.
        load({4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 8'd255}, S9, S8, S7, S6, S5, S2, S5, S5, 12'h255);
        run(5);
        chk("conv_busy_mid", dut.u_conv.busy, 1'b1);
        do_reset(3);
        chk("pts_after_abort", dut.pts_bcd, 12'h000);

        load({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd7}, LZ, LZ, LZ, S0, S0, LZ, LZ, S7, 12'h007);
        run(8);
        chk("pts_before_done", dut.pts_bcd, 12'h000);
        run(248);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
